dmem_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/rr_picker.sv | 48 ++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory subsystem: memory geometry,
// arbiter state encoding and fixed requester slots.
package cpu_pkg;

  localparam int DMEM_AW = 9;
  localparam int DMEM_DW = 8;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Successor of a requester index, wrapping back to 0 after the last one
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: chooses the first requester at or after
// rr_ptr, or only the lock owner while a lock is held.
module rr_picker
  import cpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  input  logic            lock_valid,
  input  logic [IW-1:0]   lock_owner,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Scan requesters in rotating order; a held lock masks everyone but the owner
  always_comb begin
    winner   = '0;
    index    = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (lock_valid) begin
      if (req[lock_owner]) begin
        winner[lock_owner] = 1'b1;
        index              = lock_owner;
        any                = 1'b1;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        cand_idx = IW'(cand);
        if (!any && req[cand_idx]) begin
          winner[cand_idx] = 1'b1;
          index            = cand_idx;
          any              = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with RMW lock in front of the single-port synchronous
// dmem macro. Every access is one GRANT cycle followed by one IDLE cycle, and
// all memory control comes straight from flops.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DMEM_AW,
  parameter int DW   = DMEM_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ-1:0]  lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            lock_valid_q, lock_valid_d;
  logic [IW-1:0]   lock_owner_q, lock_owner_d;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .lock_valid (lock_valid_q),
    .lock_owner (lock_owner_q),
    .winner     (pick_onehot),
    .index      (pick_idx),
    .any        (pick_any)
  );

  // State and output registers; reset kills an in-flight access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  // Next state: leave IDLE only when the picker has a winner; GRANT lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register next values: launch the winner's access, then retire it and update priority/lock
  always_comb begin
    gnt_d        = '0;
    rvalid_d     = '0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_onehot;
          mem_en_d    = 1'b1;
          mem_we_d    = we[pick_idx];
          mem_addr_d  = addr[pick_idx*AW +: AW];
          mem_wdata_d = wdata[pick_idx*DW +: DW];
          win_d       = pick_idx;
        end
      end
      GRANT: begin
        rr_ptr_d     = IW'(next_index(int'(win_q), NREQ));
        lock_valid_d = lock[win_q];
        lock_owner_d = win_q;
        if (!mem_we_q) rvalid_d[win_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic from
// two requesters checked against a transaction-level arbitration model.
module tb_dmem_arbiter;

  localparam int N   = 2;
  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int IWB = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [7:0] macro_mem [512];
  logic [7:0] ref_mem   [512];
  logic       mem_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  int            m_prev_win, m_cur_win, m_next_win, m_rv_next, m_prio, m_owner;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata_exp;
  logic [N-1:0]  exp_gnt, exp_rv;

  dmem_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous 512x8 macro model, preloaded with a known pattern on the first edge
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) macro_mem[9'(i)] <= 8'(i) ^ 8'h5A;
      macro_mem[9'h012] <= 8'hA5;
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) macro_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= macro_mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic r_req, input logic r_we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r_lock);
    req[IWB'(r)]     = r_req;
    we[IWB'(r)]      = r_we;
    lock[IWB'(r)]    = r_lock;
    addr[r*AW +: AW]  = a;
    wdata[r*DW +: DW] = d;
  endtask

  task automatic newRequest(input int r);
    if ($urandom_range(3, 0) == 0)
      applyStimulus(r, 1'b1, 1'b0, 9'($urandom_range(511, 0)), 8'h00, 1'b1);
    else
      applyStimulus(r, 1'b1, 1'($urandom), 9'($urandom_range(511, 0)), 8'($urandom), 1'b0);
  endtask

  // One complete unlocked access from an idle arbiter, checking both of its cycles
  task automatic singleAccess(input string tag, input int r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[IWB'(r)] = 1'b1;
    applyStimulus(r, 1'b1, w, a, d, 1'b0);
    tick();
    checkOutput({tag, "_gnt"},    32'(gnt), 32'(onehot));
    checkOutput({tag, "_en"},     32'(mem_en), 1);
    checkOutput({tag, "_we"},     32'(mem_we), 32'(w));
    checkOutput({tag, "_addr"},   32'(mem_addr), 32'(a));
    if (w) checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
    tick();
    applyStimulus(r, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    checkOutput({tag, "_gnt_off"}, 32'(gnt), 0);
    checkOutput({tag, "_en_off"},  32'(mem_en), 0);
    checkOutput({tag, "_rvalid"},  32'(rvalid), w ? 0 : 32'(onehot));
    if (w) ref_mem[a] = d;
    else   checkOutput({tag, "_rdata"}, 32'(rdata), 32'(ref_mem[a]));
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 512; i++) ref_mem[9'(i)] = 8'(i) ^ 8'h5A;
    ref_mem[9'h012] = 8'hA5;

    // Reset values
    tick(); tick();
    checkOutput("rst_gnt",    32'(gnt), 0);
    checkOutput("rst_rvalid", 32'(rvalid), 0);
    checkOutput("rst_en",     32'(mem_en), 0);
    checkOutput("rst_we",     32'(mem_we), 0);
    checkOutput("rst_addr",   32'(mem_addr), 0);
    checkOutput("rst_wdata",  32'(mem_wdata), 0);
    rst_n = 1'b1;
    tick();

    // Single read of preloaded 0x012
    applyStimulus(0, 1'b1, 1'b0, 9'h012, 8'h00, 1'b0);
    tick();
    checkOutput("single_gnt",  32'(gnt), 'h1);
    checkOutput("single_addr", 32'(mem_addr), 'h012);
    checkOutput("single_en",   32'(mem_en), 1);
    checkOutput("single_rv0",  32'(rvalid), 0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    checkOutput("single_rvalid", 32'(rvalid), 'h1);
    checkOutput("single_rdata",  32'(rdata), 'hA5);
    checkOutput("single_gnt_off", 32'(gnt), 0);
    tick();

    // Contention: both requesters held from reset must alternate 0,1,0,1
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 9'h100, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 9'h101, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_gnt = (k % 4 == 0) ? 2'b01 : (k % 4 == 2) ? 2'b10 : 2'b00;
      exp_rv  = (k % 4 == 1) ? 2'b01 : (k % 4 == 3) ? 2'b10 : 2'b00;
      checkOutput("cont_gnt",    32'(gnt), 32'(exp_gnt));
      checkOutput("cont_rvalid", 32'(rvalid), 32'(exp_rv));
      checkOutput("cont_onehot", 32'($countones(gnt) > 1), 0);
      if (k % 4 == 1) checkOutput("cont_rdata0", 32'(rdata), 32'(ref_mem[9'h100]));
      if (k % 4 == 3) checkOutput("cont_rdata1", 32'(rdata), 32'(ref_mem[9'h101]));
    end

    // Locked read-modify-write by requester 0 while requester 1 waits
    applyStimulus(1, 1'b1, 1'b0, 9'h0AA, 8'h00, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 9'h040, 8'h00, 1'b1);
    tick();
    checkOutput("lock_rd_gnt",  32'(gnt), 'h1);
    checkOutput("lock_rd_addr", 32'(mem_addr), 'h040);
    tick();
    checkOutput("lock_rd_rvalid", 32'(rvalid), 'h1);
    checkOutput("lock_rd_rdata",  32'(rdata), 'h1A);
    applyStimulus(0, 1'b1, 1'b1, 9'h040, 8'h07, 1'b0);
    tick();
    checkOutput("lock_wr_gnt",   32'(gnt), 'h1);
    checkOutput("lock_wr_we",    32'(mem_we), 1);
    checkOutput("lock_wr_wdata", 32'(mem_wdata), 'h07);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    checkOutput("lock_gap_gnt", 32'(gnt), 0);
    ref_mem[9'h040] = 8'h07;
    tick();
    checkOutput("lock_req1_gnt",  32'(gnt), 'h2);
    checkOutput("lock_req1_addr", 32'(mem_addr), 'h0AA);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    checkOutput("lock_req1_rvalid", 32'(rvalid), 'h2);
    checkOutput("lock_req1_rdata",  32'(rdata), 'hF0);
    tick();
    singleAccess("lock_verify", 0, 1'b0, 9'h040, 8'h00);

    // Requester 1 pulses req only during requester 0's GRANT cycle
    applyStimulus(0, 1'b1, 1'b0, 9'h033, 8'h00, 1'b0);
    tick();
    checkOutput("wd_gnt0", 32'(gnt), 'h1);
    applyStimulus(1, 1'b1, 1'b0, 9'h077, 8'h00, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    checkOutput("wd_rvalid0", 32'(rvalid), 'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("wd_no_gnt", 32'(gnt), 0);
      checkOutput("wd_no_en",  32'(mem_en), 0);
    end

    // Reset asserted in the middle of a write GRANT cycle
    applyStimulus(0, 1'b1, 1'b1, 9'h050, 8'h99, 1'b0);
    tick();
    checkOutput("rst_mid_pre_en", 32'(mem_en), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_en",     32'(mem_en), 0);
    checkOutput("rst_mid_gnt",    32'(gnt), 0);
    checkOutput("rst_mid_rvalid", 32'(rvalid), 0);
    applyStimulus(0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 9'h012, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 9'h0AA, 8'h00, 1'b0);
    tick();
    checkOutput("rst_ptr0_gnt", 32'(gnt), 'h1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    tick();
    checkOutput("rst_req1_gnt",  32'(gnt), 'h2);
    checkOutput("rst_req1_addr", 32'(mem_addr), 'h0AA);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
    checkOutput("rst_req1_rvalid", 32'(rvalid), 'h2);
    checkOutput("rst_req1_rdata",  32'(rdata), 'hF0);
    tick();

    // Top-of-memory address
    singleAccess("wrap_wr", 0, 1'b1, 9'h1FF, 8'h3C);
    singleAccess("wrap_rd", 0, 1'b0, 9'h1FF, 8'h00);
    checkOutput("wrap_rdata_const", 32'(rdata), 'h3C);

    // Random traffic against the arbitration model, starting from a clean reset
    rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    tick();
    rst_n = 1'b1;
    m_prev_win = -1; m_cur_win = -1; m_prio = 0; m_owner = -1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata_exp = '0;
    checkOutput("rnd_start_gnt", 32'(gnt), 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (m_prev_win == r) begin
          if (lock[IWB'(r)])
            applyStimulus(r, 1'b1, 1'b1, addr[r*AW +: AW], 8'($urandom), 1'b0);
          else if ($urandom_range(1, 0) == 1)
            newRequest(r);
          else
            applyStimulus(r, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);
        end else if (!req[IWB'(r)] && $urandom_range(2, 0) == 0) begin
          newRequest(r);
        end
      end

      m_rv_next  = -1;
      m_next_win = -1;
      if (m_cur_win >= 0) begin
        if (!m_we) begin
          m_rv_next   = m_cur_win;
          m_rdata_exp = ref_mem[m_addr];
        end else begin
          ref_mem[m_addr] = m_wdata;
        end
        m_prio  = (m_cur_win + 1) % N;
        m_owner = lock[IWB'(m_cur_win)] ? m_cur_win : -1;
      end else begin
        if (m_owner >= 0) begin
          if (req[IWB'(m_owner)]) m_next_win = m_owner;
        end else begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_prio + k) % N;
            if (m_next_win < 0 && req[IWB'(c)]) m_next_win = c;
          end
        end
        if (m_next_win >= 0) begin
          m_we    = we[IWB'(m_next_win)];
          m_addr  = addr[m_next_win*AW +: AW];
          m_wdata = wdata[m_next_win*DW +: DW];
        end
      end

      tick();
      exp_gnt = '0;
      exp_rv  = '0;
      if (m_next_win >= 0) exp_gnt[IWB'(m_next_win)] = 1'b1;
      if (m_rv_next >= 0)  exp_rv[IWB'(m_rv_next)]   = 1'b1;
      checkOutput("rnd_gnt",    32'(gnt), 32'(exp_gnt));
      checkOutput("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
      checkOutput("rnd_en",     32'(mem_en), 32'(m_next_win >= 0));
      if (m_next_win >= 0) begin
        checkOutput("rnd_we",   32'(mem_we), 32'(m_we));
        checkOutput("rnd_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) checkOutput("rnd_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      if (m_rv_next >= 0) checkOutput("rnd_rdata", 32'(rdata), 32'(m_rdata_exp));
      m_prev_win = m_cur_win;
      m_cur_win  = m_next_win;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
